prot_block_rot_seq: RTL and testbench
=====================================

// Module: prot_block_rot_seq
// PURPOSE
//  Sequencer for a protected-envelope data block using a rot-N Caesar data_method.
//  On start it runs a runtime license handshake: request, then compare the returned
//  value to the match value. On pass it streams exactly byte_count bytes through a
//  rot-N letter decoder over valid/ready.
//  Sits between the envelope byte parser (upstream) and the decoded-source consumer (downstream).
// PARAMETERS
//  LEN_W       16   width of byte_count and internal byte counter
//  ROT         13   Caesar rotation applied to letters (0..25)
//  LIC_MATCH   42   license response value that grants access (8-bit)
//  LIC_TMO     255  license-wait timeout in cycles (PROT_LIC_TMO_EN only)
// PORTS
//  clk         in   1      clock, all logic rising-edge
//  rst         in   1      synchronous reset, active-high
//  start       in   1      begin one block; sampled only in IDLE
//  byte_count  in   LEN_W  block length (bytes=); captured with start
//  lic_req     out  1      license check request, held high until lic_ack
//  lic_ack     in   1      license checker response strobe
//  lic_val     in   8      license response value, valid with lic_ack
//  in_valid    in   1      encrypted byte valid
//  in_data     in   8      encrypted byte
//  in_ready    out  1      block accepts in_data
//  out_valid   out  1      decoded byte valid
//  out_data    out  8      decoded byte
//  out_last    out  1      marks final byte of block, qualified by out_valid
//  out_ready   in   1      consumer accepts out_data
//  busy        out  1      state != IDLE
//  done        out  1      one-cycle pulse: block fully delivered
//  err         out  1      sticky: license mismatch or timeout; cleared by next accepted start
// BEHAVIOUR
//  Reset: state=IDLE; lic_req, in_ready, out_valid, out_last, busy and done all 0; err=0; out_data=0; counters=0.
//  FSM: IDLE -start-> LIC_REQ (capture byte_count, clear err) -> LIC_WAIT (lic_req=1)
//   LIC_WAIT: lic_ack & lic_val==LIC_MATCH -> STREAM, or DRAIN if byte_count==0
//   LIC_WAIT: lic_ack & mismatch -> ERR
//   STREAM: on last input handshake -> DRAIN; DRAIN: when out buffer empty -> DONE
//   DONE: done=1 for one cycle -> IDLE; ERR: err=1 -> IDLE next cycle
//  Zero-length block emits no output beats; done pulses after the license pass.
//  lic_req rises the cycle after start. It drops in the cycle after lic_ack is seen.
//  lic_ack outside LIC_WAIT is ignored.
//  start while busy is ignored; byte_count is not re-captured.
//  in_ready = (state==STREAM) & (!out_valid | out_ready); one-entry output register.
//  Latency: byte accepted at cycle N appears on out_data at N+1.
//  Throughput is 1 byte/cycle when out_ready is held high.
//  out_data/out_valid hold stable while out_valid & !out_ready.
//  Decode (inverse of encrypt): for 'A'..'Z', out = 'A'+((in-'A'+26-ROT) mod 26).
//   'a'..'z' are decoded the same way with base 'a'. All other bytes pass unchanged.
//  Remaining-byte counter decrements per input handshake. out_last=1 on the beat whose counter hit 0.
//  Reset mid-operation: immediate return to reset values. No done pulse, partial output discarded.
// CONFIGURATION
//  PROT_LIC_TMO_EN defined: LIC_WAIT counts cycles.
//   After LIC_TMO cycles without lic_ack: go to ERR, err=1, lic_req=0.
//   A lic_ack in the same cycle as the timeout wins.
//  Not defined: no counter; LIC_WAIT waits indefinitely; LIC_TMO unused.
// TESTING
//  T1 start, byte_count=3, lic_ack with lic_val=42, in "ert" -> out "reg", out_last on 3rd, one done pulse
//  T2 lic_val=41 on lic_ack -> err=1, no in_ready, busy drops; next start clears err
//  T3 byte_count=0, pass -> no out_valid, done 1 pulse after pass, back to IDLE
//  T4 byte_count=5, "n #5=" with out_ready toggled 1010 -> out "a #5=" stable under stall, no loss or duplication
//  T5 rst asserted mid-STREAM after 2 of 4 bytes -> all outputs at reset values next cycle, no done
//  T6 (PROT_LIC_TMO_EN, LIC_TMO=8) no lic_ack -> err=1 exactly 8 cycles into LIC_WAIT, lic_req=0

Source files
------------

// File: rtl/prot_block_rot_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : prot_block_rot_seq_if
//  Description : Signal bundle for the protected-block rot-N sequencer:
//                start/length, license handshake, input and output streams,
//                and status. master = controlling side, slave = sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
interface prot_block_rot_seq_if #(
  parameter int LEN_W = 16
) ();
  logic             start;
  logic [LEN_W-1:0] byte_count;
  logic             lic_req;
  logic             lic_ack;
  logic [7:0]       lic_val;
  logic             in_valid;
  logic [7:0]       in_data;
  logic             in_ready;
  logic             out_valid;
  logic [7:0]       out_data;
  logic             out_last;
  logic             out_ready;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output start, byte_count, lic_ack, lic_val, in_valid, in_data, out_ready,
    input  lic_req, in_ready, out_valid, out_data, out_last, busy, done, err
  );

  modport slave (
    input  start, byte_count, lic_ack, lic_val, in_valid, in_data, out_ready,
    output lic_req, in_ready, out_valid, out_data, out_last, busy, done, err
  );
endinterface
`default_nettype wire

// File: rtl/prot_block_rot_seq.sv
`default_nettype none
// ============================================================================
//  Module      : prot_block_rot_seq
//  Description : Protected-envelope block sequencer. Runs a license handshake
//                on start, then streams byte_count bytes through a rot-N
//                Caesar decoder with a one-entry output register.
//                Optional feature macro: PROT_LIC_TMO_EN (license-wait timeout).
//  Revision    : 1.0  initial release
// ============================================================================
module prot_block_rot_seq #(
  parameter int LEN_W     = 16,
  parameter int ROT       = 13,
  parameter int LIC_MATCH = 42,
  parameter int LIC_TMO   = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  prot_block_rot_seq_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LIC_REQ  = 3'd1,
    S_LIC_WAIT = 3'd2,
    S_STREAM   = 3'd3,
    S_DRAIN    = 3'd4,
    S_DONE     = 3'd5,
    S_ERR      = 3'd6
  } state_t;

  // Backward shift expressed as a forward add keeps the arithmetic unsigned.
  localparam logic [7:0] c_BACK  = 8'(26 - ROT);
  localparam logic [7:0] c_MATCH = 8'(LIC_MATCH);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [LEN_W-1:0] r_remain;
  logic             r_out_valid;
  logic [7:0]       r_out_data;
  logic             r_out_last;
  logic             r_err;
  logic             w_in_ready;
  logic             w_in_hs;
  logic             w_start_ok;
  logic             w_tmo;

  function automatic logic [7:0] f_rot_dec(input logic [7:0] b);
    logic [7:0] v;
    v = b;
    if (b >= 8'h41 && b <= 8'h5A) begin
      v = b - 8'h41 + c_BACK;
      if (v >= 8'd26) v = v - 8'd26;
      v = v + 8'h41;
    end else if (b >= 8'h61 && b <= 8'h7A) begin
      v = b - 8'h61 + c_BACK;
      if (v >= 8'd26) v = v - 8'd26;
      v = v + 8'h61;
    end
    return v;
  endfunction

  assign w_start_ok = (r_state == S_IDLE) && bus.start;
  assign w_in_ready = (r_state == S_STREAM) && (!r_out_valid || bus.out_ready);
  assign w_in_hs    = w_in_ready && bus.in_valid;

`ifdef PROT_LIC_TMO_EN
  localparam int c_TMO_W = (LIC_TMO > 1) ? $clog2(LIC_TMO) : 1;

  logic [c_TMO_W-1:0] r_tmo_cnt;

  // Count license-wait cycles without an ack; restarts whenever LIC_WAIT is left.
  always_ff @(posedge clk) begin
    if (rst || r_state != S_LIC_WAIT) begin
      r_tmo_cnt <= '0;
    end else if (!bus.lic_ack) begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end

  // An ack arriving on the expiry cycle takes precedence over the timeout.
  assign w_tmo = (r_state == S_LIC_WAIT) && !bus.lic_ack &&
                 (r_tmo_cnt == c_TMO_W'(LIC_TMO - 1));
`else
  assign w_tmo = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state decode for the license / stream / drain sequence.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:     if (bus.start) w_state_nxt = S_LIC_REQ;
      S_LIC_REQ:  w_state_nxt = S_LIC_WAIT;
      S_LIC_WAIT: begin
        if (bus.lic_ack) begin
          if (bus.lic_val == c_MATCH)
            w_state_nxt = (r_remain == '0) ? S_DRAIN : S_STREAM;
          else
            w_state_nxt = S_ERR;
        end else if (w_tmo) begin
          w_state_nxt = S_ERR;
        end
      end
      S_STREAM:   if (w_in_hs && r_remain == LEN_W'(1)) w_state_nxt = S_DRAIN;
      S_DRAIN:    if (!r_out_valid) w_state_nxt = S_DONE;
      S_DONE:     w_state_nxt = S_IDLE;
      S_ERR:      w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  // Remaining-byte counter: loaded on an accepted start, decremented per input beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_remain <= '0;
    end else if (w_start_ok) begin
      r_remain <= bus.byte_count;
    end else if (w_in_hs) begin
      r_remain <= r_remain - 1'b1;
    end
  end

  // One-entry output register; holds its beat while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= 8'h00;
      r_out_last  <= 1'b0;
    end else if (w_in_hs) begin
      r_out_valid <= 1'b1;
      r_out_data  <= f_rot_dec(bus.in_data);
      r_out_last  <= (r_remain == LEN_W'(1));
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end
  end

  // Sticky error: set on license mismatch/timeout, cleared by the next accepted start.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_start_ok) begin
      r_err <= 1'b0;
    end else if (r_state == S_LIC_WAIT && w_state_nxt == S_ERR) begin
      r_err <= 1'b1;
    end
  end

  // lic_req covers LIC_REQ so it rises the cycle after start.
  assign bus.lic_req   = (r_state == S_LIC_REQ) || (r_state == S_LIC_WAIT);
  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_last  = r_out_last;
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.done      = (r_state == S_DONE);
  assign bus.err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_prot_block_rot_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_prot_block_rot_seq
//  Description : Self-checking bench for prot_block_rot_seq with a scoreboard
//                of expected output beats.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_prot_block_rot_seq;

  localparam int TB_LEN_W = 16;
  localparam int TB_ROT   = 13;
  localparam int TB_MATCH = 42;
  localparam int TB_TMO   = 8;

  logic clk;
  logic rst;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] stim[$];
  logic [7:0] want[$];
  logic [8:0] sb[$];

  prot_block_rot_seq_if #(.LEN_W(TB_LEN_W)) bus ();

  prot_block_rot_seq #(
    .LEN_W    (TB_LEN_W),
    .ROT      (TB_ROT),
    .LIC_MATCH(TB_MATCH),
    .LIC_TMO  (TB_TMO)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_dec(input logic [7:0] c);
    int k;
    if (c >= 8'h41 && c <= 8'h5A) begin
      k = (int'(c) - 65 + 26 - TB_ROT) % 26;
      return 8'(65 + k);
    end
    if (c >= 8'h61 && c <= 8'h7A) begin
      k = (int'(c) - 97 + 26 - TB_ROT) % 26;
      return 8'(97 + k);
    end
    return c;
  endfunction

  function automatic logic [14:0] out_vec();
    return {bus.lic_req, bus.in_ready, bus.out_valid, bus.out_last,
            bus.busy, bus.done, bus.err, bus.out_data};
  endfunction

  task automatic load(input string enc, input string dec);
    stim.delete();
    want.delete();
    for (int i = 0; i < enc.len(); i++) stim.push_back(enc[i]);
    for (int i = 0; i < dec.len(); i++) want.push_back(dec[i]);
  endtask

  task automatic do_start(input logic [TB_LEN_W-1:0] cnt);
    @(posedge clk); #1;
    bus.start      = 1'b1;
    bus.byte_count = cnt;
    @(posedge clk); #1;
    bus.start      = 1'b0;
    bus.byte_count = '1;
    @(negedge clk);
    check_val("start_lic_req", bus.lic_req, 1);
    check_val("start_busy_err", {bus.busy, bus.err}, 2'b10);
  endtask

  task automatic do_lic(input logic [7:0] val);
    @(posedge clk); #1;
    bus.lic_ack = 1'b1;
    bus.lic_val = val;
    @(posedge clk); #1;
    bus.lic_ack = 1'b0;
    bus.lic_val = 8'h00;
    @(negedge clk);
    check_val("lic_req_drop", bus.lic_req, 0);
  endtask

  task automatic run_stream(input logic [3:0] pat, input bit rand_rdy);
    int idx, cyc, done_cnt, n;
    bit pend;
    logic [8:0] e;
    idx = 0; cyc = 0; done_cnt = 0; pend = 1'b0;
    n = stim.size();
    sb.delete();
    while (cyc < 200) begin
      @(posedge clk); #1;
      bus.in_valid  = (idx < n);
      bus.in_data   = (idx < n) ? stim[idx] : 8'h00;
      bus.out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : pat[3 - (cyc % 4)];
      @(negedge clk);
      if (pend) begin
        check_val("latency", bus.out_valid, 1);
        pend = 1'b0;
      end
      if (bus.done) done_cnt++;
      if (bus.out_valid) begin
        if (sb.size() == 0) begin
          check_val("extra_beat", bus.out_valid, 0);
        end else if (!bus.out_ready) begin
          check_val("stall_hold", {bus.out_last, bus.out_data}, sb[0]);
        end else begin
          e = sb.pop_front();
          check_val("beat", {bus.out_last, bus.out_data}, e);
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        sb.push_back({(idx == n - 1), want[idx]});
        idx++;
        pend = 1'b1;
      end
      cyc++;
      if (done_cnt > 0 && !bus.done) break;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check_val("bytes_in", idx, n);
    check_val("sb_empty", sb.size(), 0);
    check_val("done_pulses", done_cnt, 1);
    check_val("idle_after", bus.busy, 0);
  endtask

  initial begin
    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.byte_count = '0;
    bus.lic_ack    = 1'b0;
    bus.lic_val    = 8'h00;
    bus.in_valid   = 1'b0;
    bus.in_data    = 8'h00;
    bus.out_ready  = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("reset_vec", out_vec(), 15'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // T1: "ert" -> "reg"
    load("ert", "reg");
    do_start(3);
    do_lic(8'd42);
    run_stream(4'b1111, 1'b0);

    // T2: license mismatch
    do_start(2);
    do_lic(8'd41);
    check_val("t2_err_state", {bus.err, bus.in_ready, bus.busy}, 3'b101);
    @(negedge clk);
    check_val("t2_idle_err", {bus.busy, bus.err}, 2'b01);

    // T3: zero-length block (start also clears err)
    load("", "");
    do_start(0);
    do_lic(8'd42);
    run_stream(4'b1111, 1'b0);

    // T4: stalls with out_ready 1010
    load("n #5=", "a #5=");
    do_start(5);
    do_lic(8'd42);
    run_stream(4'b1010, 1'b0);

`ifdef PROT_LIC_TMO_EN
    // T6: license timeout
    do_start(3);
    for (int k = 0; k < TB_TMO; k++) begin
      @(negedge clk);
      check_val("t6_wait", {bus.lic_req, bus.err}, 2'b10);
    end
    @(negedge clk);
    check_val("t6_timeout", {bus.lic_req, bus.err, bus.busy}, 3'b011);
    @(negedge clk);
    check_val("t6_idle", bus.busy, 0);
`endif

    // T7: random bytes with random backpressure
    stim.delete();
    want.delete();
    for (int i = 0; i < 12; i++) begin
      stim.push_back(8'($urandom_range(0, 255)));
      want.push_back(model_dec(stim[i]));
    end
    do_start(12);
    do_lic(8'd42);
    run_stream(4'b1111, 1'b1);

    // T5: reset mid-stream after 2 of 4 bytes
    do_start(4);
    do_lic(8'd42);
    @(posedge clk); #1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h61;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check_val("t5_ready", bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_data = 8'h62;
    @(negedge clk);
    check_val("t5_first", {bus.out_valid, bus.out_data}, {1'b1, 8'h6E});
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check_val("t5_second", {bus.out_valid, bus.out_last, bus.out_data}, {2'b10, 8'h6F});
    @(posedge clk); #1;
    @(negedge clk);
    check_val("t5_reset_vec", out_vec(), 15'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_val("t5_no_done", {bus.done, bus.busy}, 2'b00);

    // Recovery after reset: single byte block
    load("N", "A");
    do_start(1);
    do_lic(8'd42);
    run_stream(4'b1111, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
